load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have one parameter: address_width, default 10, byte-address width of the attached data memory (2**address_width bytes).
REQ-002 The block SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port req_valid, input, 1, pipeline access request valid.
REQ-005 The block SHALL have port req_ready, output, 1, block can accept a request.
REQ-006 The block SHALL have port req_write, input, 1, 1 = store, 0 = load.
REQ-007 The block SHALL have port req_funct3, input, 3, RV32I width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 The block SHALL have port req_addr, input, 32, byte address.
REQ-009 The block SHALL have port req_wdata, input, 32, store data; B/H use the low 8/16 bits.
REQ-010 The block SHALL have port resp_valid, output, 1, one-cycle completion pulse; no backpressure.
REQ-011 The block SHALL have port resp_rdata, output, 32, extended load result; 0 for stores and faults.
REQ-012 The block SHALL have port resp_misaligned, output, 1, misaligned-access flag; valid with resp_valid.
REQ-013 The block SHALL have port resp_error, output, 1, illegal funct3 or out-of-range address flag; valid with resp_valid.
REQ-014 The block SHALL have port mem_address, output, 32, word-aligned memory address ({addr[31:2],2'b00}).
REQ-015 The block SHALL have port mem_write_data, output, 32, memory write word.
REQ-016 The block SHALL have port mem_write, output, 1, memory write enable; write occurs at the rising edge where it is high.
REQ-017 The block SHALL have port mem_read, output, 1, memory read enable.
REQ-018 The block SHALL have port mem_read_data, input, 32, memory read word; valid the cycle after mem_read is high.

Function
REQ-019 The FSM SHALL have states IDLE, RD, CAP, WR, RESP; req_ready = 1 only in IDLE; one outstanding access.
REQ-020 On acceptance (req_valid & req_ready), the block SHALL register write, funct3, addr and wdata; inputs are ignored thereafter until IDLE.
REQ-021 Classification SHALL be in priority order: error (funct3 not in {000,001,010,100,101} for loads or not in {000,001,010} for stores, or any addr bit at or above address_width set), then misaligned (H with addr[0]=1, W with addr[1:0]!=0), then normal.
REQ-022 Error or misaligned requests SHALL go IDLE->RESP with no mem_read or mem_write asserted.
REQ-023 Loads SHALL go IDLE->RD (mem_read=1 for exactly one cycle)->CAP (capture mem_read_data)->RESP, giving resp_valid 3 cycles after the accept edge.
REQ-024 In CAP, a load SHALL select little-endian lane addr[1:0] (byte lane 8*off, halfword lane 16*addr[1]), sign-extend for B/H and zero-extend for BU/HU, and register the result into resp_rdata.
REQ-025 SW SHALL go IDLE->WR (mem_write=1 for one cycle, mem_write_data = wdata)->RESP.
REQ-026 SB/SH SHALL go IDLE->RD->CAP (merge wdata low byte/halfword into the captured word at its lane; other bytes unchanged)->WR (write merged word)->RESP.
REQ-027 mem_read and mem_write SHALL never be high in the same cycle; both SHALL be 0 outside RD and WR respectively.
REQ-028 resp_valid SHALL be high only in RESP, for exactly one cycle, and the next state SHALL be IDLE.
REQ-029 resp_misaligned, resp_error and resp_rdata SHALL hold their values until the next response.

Reset
REQ-030 While rst_n=0, the block SHALL immediately force state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_misaligned=0, resp_error=0, mem_read=0, mem_write=0, mem_address=0 and mem_write_data=0.
REQ-031 Reset asserted mid-access SHALL abort the access: no later mem_write and no resp_valid for the aborted request.

Verification
REQ-032 SW 0x4 <- 0xAABBCCDD, then LW 0x4 -> resp_rdata=0xAABBCCDD, resp_valid 3 cycles after accept, flags 0.
REQ-033 With word 0x4=0xAABBCCDD: LB 0x7 -> 0xFFFFFFAA; LBU 0x7 -> 0x000000AA; LH 0x4 -> 0xFFFFCCDD; LHU 0x6 -> 0x0000AABB.
REQ-034 SB 0x5 <- 0x12345611 -> word 0x4 becomes 0xAABB11DD; exactly one mem_read then one mem_write; resp_valid 4 cycles after accept.
REQ-035 LW 0x6 and SH 0x5 -> resp_misaligned=1, resp_error=0, resp_rdata=0; no memory enable asserted; memory unchanged.
REQ-036 Load with funct3=011, or LW 0x400 with address_width=10 -> resp_error=1, resp_misaligned=0, no memory activity.
REQ-037 Assert rst_n=0 during RD of SB 0x5 -> mem_write never asserts, no resp_valid, word 0x4 unchanged, req_ready=1 after release.

Source files
------------

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I byte/half/word load-store unit in front of a word-wide data memory.
// One access at a time; sub-word stores are done as read-modify-write of the containing word.
module load_store_unit #(
  parameter int address_width = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misaligned,
  output logic        resp_error,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

  state_t      state_q, state_d;
  logic        write_q, write_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic [15:0] wdata_q, wdata_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic [31:0] mem_write_data_q, mem_write_data_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_misaligned_q, resp_misaligned_d;
  logic        resp_error_q, resp_error_d;

  logic        f3_legal, out_of_range, misaligned, req_error;
  logic [4:0]  byte_shift;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_value;
  logic [31:0] merged_word;

  // Request classification on the raw inputs, used only at the accept edge
  always_comb begin
    f3_legal = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
      3'b100, 3'b101:         f3_legal = !req_write;
      default:                f3_legal = 1'b0;
    endcase
    out_of_range = (req_addr >> address_width) != 32'd0;
    misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    req_error    = !f3_legal || out_of_range;
  end

  always_comb begin
    byte_shift  = {off_q, 3'b000};
    load_byte   = 8'(mem_read_data >> byte_shift);
    load_half   = off_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
    load_value  = mem_read_data;
    case (funct3_q)
      3'b000:  load_value = {{24{load_byte[7]}}, load_byte};
      3'b100:  load_value = {24'd0, load_byte};
      3'b001:  load_value = {{16{load_half[15]}}, load_half};
      3'b101:  load_value = {16'd0, load_half};
      default: load_value = mem_read_data;
    endcase
    merged_word = mem_read_data;
    if (funct3_q[1:0] == 2'b00) begin
      merged_word[byte_shift +: 8] = wdata_q[7:0];
    end else begin
      merged_word[{off_q[1], 4'b0000} +: 16] = wdata_q;
    end
  end

  // Response registers only change on entry to RESP so they hold between responses
  always_comb begin
    state_d           = state_q;
    write_d           = write_q;
    funct3_d          = funct3_q;
    off_d             = off_q;
    wdata_d           = wdata_q;
    mem_address_d     = mem_address_q;
    mem_write_data_d  = mem_write_data_q;
    resp_rdata_d      = resp_rdata_q;
    resp_misaligned_d = resp_misaligned_q;
    resp_error_d      = resp_error_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d       = req_write;
          funct3_d      = req_funct3;
          off_d         = req_addr[1:0];
          wdata_d       = req_wdata[15:0];
          mem_address_d = {req_addr[31:2], 2'b00};
          if (req_error || misaligned) begin
            state_d           = RESP;
            resp_error_d      = req_error;
            resp_misaligned_d = !req_error;
            resp_rdata_d      = 32'd0;
          end else if (req_write && (req_funct3 == 3'b010)) begin
            state_d          = WR;
            mem_write_data_d = req_wdata;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: state_d = CAP;
      CAP: begin
        if (write_q) begin
          mem_write_data_d = merged_word;
          state_d          = WR;
        end else begin
          resp_rdata_d      = load_value;
          resp_misaligned_d = 1'b0;
          resp_error_d      = 1'b0;
          state_d           = RESP;
        end
      end
      WR: begin
        resp_rdata_d      = 32'd0;
        resp_misaligned_d = 1'b0;
        resp_error_d      = 1'b0;
        state_d           = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= IDLE;
      write_q           <= 1'b0;
      funct3_q          <= 3'd0;
      off_q             <= 2'd0;
      wdata_q           <= 16'd0;
      mem_address_q     <= 32'd0;
      mem_write_data_q  <= 32'd0;
      resp_rdata_q      <= 32'd0;
      resp_misaligned_q <= 1'b0;
      resp_error_q      <= 1'b0;
    end else begin
      state_q           <= state_d;
      write_q           <= write_d;
      funct3_q          <= funct3_d;
      off_q             <= off_d;
      wdata_q           <= wdata_d;
      mem_address_q     <= mem_address_d;
      mem_write_data_q  <= mem_write_data_d;
      resp_rdata_q      <= resp_rdata_d;
      resp_misaligned_q <= resp_misaligned_d;
      resp_error_q      <= resp_error_d;
    end
  end

  assign req_ready       = (state_q == IDLE);
  assign mem_read        = (state_q == RD);
  assign mem_write       = (state_q == WR);
  assign resp_valid      = (state_q == RESP);
  assign resp_rdata      = resp_rdata_q;
  assign resp_misaligned = resp_misaligned_q;
  assign resp_error      = resp_error_q;
  assign mem_address     = mem_address_q;
  assign mem_write_data  = mem_write_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit with a byte-level reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;
  logic        resp_error;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_read_data;

  always #5 clk = ~clk;

  load_store_unit #(.address_width(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_misaligned(resp_misaligned), .resp_error(resp_error),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write(mem_write), .mem_read(mem_read), .mem_read_data(mem_read_data)
  );

  // Word memory seen by the DUT; read data appears the cycle after mem_read
  logic [31:0] tb_mem [0:255];
  logic [31:0] rd_word;
  always @(posedge clk) begin
    if (mem_read) rd_word <= tb_mem[mem_address[9:2]];
    if (mem_write) tb_mem[mem_address[9:2]] <= mem_write_data;
  end
  assign mem_read_data = rd_word;

  logic [7:0] ref_mem [0:1023];

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
    logic [31:0] waddr;
  } exp_t;
  exp_t exp_q[$];

  int ncmp = 0;
  int nfail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: architectural behaviour of one access on a byte-addressed memory
  task automatic model(input bit w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output exp_t e);
    bit legal, err, mis;
    int size;
    logic [31:0] val;
    legal = w ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    err   = !legal || (a >= 32'd1024);
    size  = 1 << f3[1:0];
    mis   = !err && ((a % size) != 0);
    e.rdata = 32'd0;
    e.err   = err;
    e.mis   = mis;
    e.waddr = a & ~32'd3;
    if (err || mis) begin
      e.lat = 1; e.nrd = 0; e.nwr = 0;
    end else if (w) begin
      for (int i = 0; i < size; i++) ref_mem[a + i] = wd[8*i +: 8];
      e.lat = (size == 4) ? 2 : 4;
      e.nrd = (size == 4) ? 0 : 1;
      e.nwr = 1;
    end else begin
      val = 32'd0;
      for (int i = 0; i < size; i++) val = val | (32'(ref_mem[a + i]) << (8 * i));
      if (!f3[2] && size == 1 && val[7])  val = val | 32'hFFFF_FF00;
      if (!f3[2] && size == 2 && val[15]) val = val | 32'hFFFF_0000;
      e.rdata = val;
      e.lat = 3; e.nrd = 1; e.nwr = 0;
    end
  endtask

  // Monitor: accepts, memory activity and responses are all sampled at negedge
  int cyc = 0, acc_cyc = 0, nrd = 0, nwr = 0;
  bit overlap = 0;
  logic [31:0] last_addr = 32'd0;
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst_n) begin
      if (mem_read && mem_write) overlap = 1;
      if (mem_read) nrd++;
      if (mem_write) nwr++;
      if (mem_read || mem_write) last_addr = mem_address;
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_misaligned", 32'(resp_misaligned), 32'(e.mis));
          chk("resp_error", 32'(resp_error), 32'(e.err));
          chk("latency", cyc - acc_cyc, e.lat);
          chk("mem_read_count", nrd, e.nrd);
          chk("mem_write_count", nwr, e.nwr);
          chk("rd_wr_overlap", 32'(overlap), 32'd0);
          if (e.nrd + e.nwr > 0) chk("mem_address", last_addr, e.waddr);
        end
      end
      if (req_valid && req_ready) begin
        acc_cyc = cyc; nrd = 0; nwr = 0; overlap = 0;
      end
    end
  end

  task automatic issue(input bit w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    int t;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
    t = 0;
    @(negedge clk);
    while (!req_ready && t < 20) begin @(negedge clk); t++; end
    if (!req_ready) begin
      chk("req_ready_timeout", 32'd0, 32'd1);
    end else begin
      model(w, f3, a, wd, e);
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 50) begin @(negedge clk); t++; end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", exp_q.size(), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_flags", {30'd0, resp_misaligned, resp_error}, 32'd0);
    chk("rst_mem_enables", {30'd0, mem_read, mem_write}, 32'd0);
    chk("rst_mem_address", mem_address, 32'd0);
    chk("rst_mem_write_data", mem_write_data, 32'd0);
  endtask

  initial begin
    int t, seen_wr, seen_resp;
    bit w;
    logic [2:0] f3;
    logic [31:0] a;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++)
      tb_mem[i] = {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]};
    repeat (2) @(negedge clk);
    chk_reset_outputs();
    @(posedge clk); #1 rst_n = 1'b1;

    issue(1, 3'b010, 32'h4, 32'hAABB_CCDD);
    issue(0, 3'b010, 32'h4, 32'h0);
    issue(0, 3'b000, 32'h7, 32'h0);
    issue(0, 3'b100, 32'h7, 32'h0);
    issue(0, 3'b001, 32'h4, 32'h0);
    issue(0, 3'b101, 32'h6, 32'h0);
    issue(1, 3'b000, 32'h5, 32'h1234_5611);
    issue(0, 3'b010, 32'h4, 32'h0);
    issue(0, 3'b010, 32'h6, 32'h0);
    issue(1, 3'b001, 32'h5, 32'hDEAD_BEEF);
    issue(0, 3'b011, 32'h8, 32'h0);
    issue(0, 3'b010, 32'h400, 32'h0);
    issue(1, 3'b100, 32'h8, 32'h0);
    drain();

    // Abort an SB to 0x5 in its read cycle
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000; req_addr = 32'h5; req_wdata = 32'h0000_0077;
    t = 0;
    @(negedge clk);
    while (!mem_read && t < 10) begin @(negedge clk); t++; end
    chk("abort_reached_rd", 32'(mem_read), 32'd1);
    #1 rst_n = 1'b0;
    req_valid = 1'b0;
    #1 chk_reset_outputs();
    @(posedge clk); #1 rst_n = 1'b1;
    seen_wr = 0; seen_resp = 0;
    repeat (8) begin
      @(negedge clk);
      if (mem_write) seen_wr++;
      if (resp_valid) seen_resp++;
    end
    chk("abort_no_write", seen_wr, 0);
    chk("abort_no_resp", seen_resp, 0);
    chk("abort_ready", 32'(req_ready), 32'd1);
    issue(0, 3'b010, 32'h4, 32'h0);
    drain();

    for (int n = 0; n < 300; n++) begin
      w = 1'($urandom);
      if ($urandom_range(0, 7) == 0) f3 = 3'($urandom);
      else if (w) f3 = 3'($urandom_range(0, 2));
      else begin
        f3 = 3'($urandom_range(0, 4));
        if (f3 == 3'd3) f3 = 3'd4;
        else if (f3 == 3'd4) f3 = 3'd5;
      end
      a = 32'($urandom_range(0, 47));
      if ($urandom_range(0, 15) == 0) a = $urandom | 32'h400;
      issue(w, f3, a, $urandom);
    end
    drain();

    for (int i = 0; i < 256; i++)
      chk($sformatf("mem_word_%0d", i), tb_mem[i],
          {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
